sha_schedule_stream: RTL
========================

# sha_schedule_stream

Streaming SHA-256 message-schedule generator: accepts one 512-bit padded block per handshake and emits the schedule words W[0..ROUNDS-1] one per cycle on a valid/ready stream. It uses a rolling 16-word window instead of a 64-word parallel array. A one-entry pending buffer lets the next block be accepted while the current one streams, so back-to-back blocks run without a bubble. It sits between the block padder and the iterative compression round engine in the miner datapath.

## Interface

- ROUNDS, 64, number of schedule words emitted per block; legal range 16..128.
- ID_W, 4, width of the block tag carried alongside each word.
- IDX_W, $clog2(ROUNDS), width of w_index; derived, do not override.
- clk  in  1  single clock; all logic is rising-edge.
- rst  in  1  synchronous, active-high reset.
- blk_valid  in  1  input block offered.
- blk_ready  out  1  block accepted when blk_valid && blk_ready.
- blk_data  in  512  padded block; W0 = [511:480], W15 = [31:0] (big-endian words).
- blk_id  in  ID_W  tag for the block.
- w_valid  out  1  w_data is valid.
- w_ready  in  1  downstream accepts the word when w_valid && w_ready.
- w_data  out  32  schedule word W[w_index].
- w_index  out  IDX_W  round index t of w_data.
- w_last  out  1  high when w_index == ROUNDS-1.
- w_id  out  ID_W  tag of the block being streamed.
- busy  out  1  high when the window or the pending buffer holds a block.

## Operation

- State: window win[0..15] (32 b each), index t, active flag, and a pending register holding a block and its id, with pend_valid.
- win[k] holds W[t+k]. Output: w_data = win[0], w_valid = active.
- On each beat (w_valid && w_ready), the window shifts down one word and win[15] is loaded with s1(win[14]) + win[9] + s0(win[1]) + win[0]. Arithmetic is mod 2^32.
  - s0(x) = rotr7 ^ rotr18 ^ shr3.
  - s1(x) = rotr17 ^ rotr19 ^ shr10.
  - No X special-casing.
- t increments on each beat. The beat with t == ROUNDS-1 ends the block.
- blk_ready = !pend_valid && !rst.
- An accepted block loads directly into the window (t = 0, active = 1) if either:
  - the window is idle, or
  - the current beat is the final one and pend_valid = 0.
- Otherwise an accepted block goes to the pending register.
- When the final beat fires and pend_valid = 1, the pending block loads into the window and pend_valid clears in the same edge.
- No beat fires (w_valid && !w_ready): window, t and pending contents hold. A block may still be accepted into pending if pend_valid = 0.
- Reset is synchronous and takes priority over every event. On reset:
  - active = 0, pend_valid = 0, t = 0.
  - Window and pending data registers need not clear.
  - A block streaming when rst rises is discarded; no further beats of it appear.

## Timing

- Reset values: w_valid 0, w_data 0, w_index 0, w_last 0, w_id 0, busy 0, blk_ready 0 while rst is high and 1 in the first cycle after.
- Latency: block accepted in cycle N with the window idle → w_valid = 1 with W0 in cycle N+1.
- Throughput: one word per cycle under w_ready = 1. Each block takes exactly ROUNDS beats.
- Back-to-back blocks: the cycle after the final beat of block A shows W0 of block B with w_index = 0, no idle cycle.
- Outputs are registered. w_last and w_index are derived from registered t.
- Pending full: blk_ready = 0 until the final beat of the current block. blk_ready returns to 1 in the following cycle.
- Output stall: w_data, w_index and w_id must stay stable while w_valid && !w_ready.

## Test plan

- "abc" padded block (0x61626380, thirteen zero words, 0x00000018), w_ready = 1 → 64 beats; W0 = 0x61626380, W15 = 0x00000018, W16 = 0x61626380, W17 = 0x000F0000; w_last only at index 63; remaining words match a reference model.
- Two blocks presented on consecutive cycles, ids 3 and 5 → the second goes to pending and blk_ready drops. Index 63 of id 3 is followed directly by index 0 of id 5; blk_ready rises the cycle after that.
- Random w_ready (50%) over 8 random blocks → every word matches the model; outputs are stable during stalls; no word is lost or duplicated.
- ROUNDS = 16 build → exactly 16 beats per block, equal to the input words; w_last at index 15.
- Block accepted on the same cycle as the final beat with pending empty → next cycle shows the new block at index 0; busy stays 1.
- rst asserted at index 20 with a block pending → next cycle w_valid = 0, busy = 0, blk_ready = 0; after release the first new block streams from index 0.

Source files
------------

// File: rtl/sha_schedule_stream.sv
// SHA-256 message-schedule streamer: one 512-bit block in, W[0..ROUNDS-1] out one word per beat; first word 1 cycle after accept.
// Backpressure: w_ready low freezes the window; a single pending slot absorbs one extra block, blk_ready drops while it is full.
module sha_schedule_stream #(
    parameter int ROUNDS = 64,
    parameter int ID_W   = 4,
    parameter int IDX_W  = $clog2(ROUNDS)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              blk_valid,
    output logic              blk_ready,
    input  logic [511:0]      blk_data,
    input  logic [ID_W-1:0]   blk_id,
    output logic              w_valid,
    input  logic              w_ready,
    output logic [31:0]       w_data,
    output logic [IDX_W-1:0]  w_index,
    output logic              w_last,
    output logic [ID_W-1:0]   w_id,
    output logic              busy
);

    localparam logic [IDX_W-1:0] LAST_T = IDX_W'(ROUNDS - 1);

    function automatic logic [31:0] sig0(input logic [31:0] x);
        return {x[6:0], x[31:7]} ^ {x[17:0], x[31:18]} ^ {3'b000, x[31:3]};
    endfunction

    function automatic logic [31:0] sig1(input logic [31:0] x);
        return {x[16:0], x[31:17]} ^ {x[18:0], x[31:19]} ^ {10'd0, x[31:10]};
    endfunction

    logic [31:0]      win_q [16];
    logic [31:0]      win_d [16];
    logic [IDX_W-1:0] t_q, t_d;
    logic             active_q, active_d;
    logic [ID_W-1:0]  id_q, id_d;
    logic [511:0]     pend_blk_q, pend_blk_d;
    logic [ID_W-1:0]  pend_id_q, pend_id_d;
    logic             pend_vld_q, pend_vld_d;

    logic             beat;
    logic             last_beat;
    logic             accept;
    logic             load_new;
    logic             load_pend;
    logic [31:0]      w_next;

    assign blk_ready = !pend_vld_q && !rst;
    assign beat      = active_q && w_ready;
    assign last_beat = beat && (t_q == LAST_T);
    assign accept    = blk_valid && blk_ready;
    // A fresh block goes straight to the window only if nothing is queued ahead of it.
    assign load_pend = last_beat && pend_vld_q;
    assign load_new  = accept && (!active_q || (last_beat && !pend_vld_q));
    assign w_next    = sig1(win_q[14]) + win_q[9] + sig0(win_q[1]) + win_q[0];

    always_comb begin
        for (int k = 0; k < 16; k++) begin
            win_d[k] = win_q[k];
        end
        t_d        = t_q;
        active_d   = active_q;
        id_d       = id_q;
        pend_blk_d = pend_blk_q;
        pend_id_d  = pend_id_q;
        pend_vld_d = pend_vld_q;

        if (beat) begin
            for (int k = 0; k < 15; k++) begin
                win_d[k] = win_q[k+1];
            end
            win_d[15] = w_next;
            t_d       = t_q + IDX_W'(1);
        end
        if (last_beat) begin
            active_d = 1'b0;
            t_d      = '0;
        end

        if (load_pend) begin
            for (int k = 0; k < 16; k++) begin
                win_d[k] = pend_blk_q[511-32*k -: 32];
            end
            t_d        = '0;
            active_d   = 1'b1;
            id_d       = pend_id_q;
            pend_vld_d = 1'b0;
        end else if (load_new) begin
            for (int k = 0; k < 16; k++) begin
                win_d[k] = blk_data[511-32*k -: 32];
            end
            t_d      = '0;
            active_d = 1'b1;
            id_d     = blk_id;
        end else if (accept) begin
            pend_blk_d = blk_data;
            pend_id_d  = blk_id;
            pend_vld_d = 1'b1;
        end
    end

    // Window and tag clear on reset so the output bus reads zero while idle after reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int k = 0; k < 16; k++) begin
                win_q[k] <= '0;
            end
            t_q        <= '0;
            active_q   <= 1'b0;
            id_q       <= '0;
            pend_vld_q <= 1'b0;
        end else begin
            for (int k = 0; k < 16; k++) begin
                win_q[k] <= win_d[k];
            end
            t_q        <= t_d;
            active_q   <= active_d;
            id_q       <= id_d;
            pend_vld_q <= pend_vld_d;
        end
    end

    always_ff @(posedge clk) begin
        pend_blk_q <= pend_blk_d;
        pend_id_q  <= pend_id_d;
    end

    assign w_valid = active_q;
    assign w_data  = win_q[0];
    assign w_index = t_q;
    assign w_last  = (t_q == LAST_T);
    assign w_id    = id_q;
    assign busy    = active_q || pend_vld_q;

endmodule
